// File: rtl/snake_body_if.sv
// snake_body_if: control inputs and snake/len outputs of one snake body.
//   step, dir_valid, dir_in, grow, freeze : driven by the master (game control)
//   snake, len, moved, self_hit           : driven by the slave (snake_body)
interface snake_body_if #(
    parameter int max_len         = 16,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4
);
    logic                         step;
    logic                         dir_valid;
    logic [1:0]                   dir_in;
    logic                         grow;
    logic                         freeze;
    logic [max_len*num_len-1:0]   snake;
    logic [max_len_bit_len-1:0]   len;
    logic                         moved;
    logic                         self_hit;

    modport master (
        output step, dir_valid, dir_in, grow, freeze,
        input  snake, len, moved, self_hit
    );

    modport slave (
        input  step, dir_valid, dir_in, grow, freeze,
        output snake, len, moved, self_hit
    );
endinterface

// File: rtl/snake_body.sv
// snake_body: one snake's body state, advanced one cell per movement tick.
//   clk, rst      : clock, synchronous active-high reset
//   bus.step      : movement tick        bus.dir_valid/dir_in : direction request
//   bus.grow      : food-eaten pulse     bus.freeze           : stop moving
//   bus.snake     : packed segments, head at [num_len-1:0]
//   bus.len       : valid segment count  bus.moved            : update pulse
//   bus.self_hit  : sticky self-collision flag
module snake_body #(
    parameter int max_len         = 16,
    parameter int num_len         = 10,
    parameter int max_len_bit_len = 4,
    parameter int GRID_W          = 32,
    parameter int GRID_H          = 24,
    parameter int INIT_X          = 5,
    parameter int INIT_Y          = 5,
    parameter int INIT_LEN        = 3
) (
    input logic       clk,
    input logic       rst,
    snake_body_if.slave bus
);
    localparam int HW = num_len / 2;
    localparam logic [HW-1:0] X_MAX = HW'(GRID_W - 1);
    localparam logic [HW-1:0] Y_MAX = HW'(GRID_H - 1);
    localparam logic [max_len_bit_len-1:0] LEN_CAP = max_len_bit_len'(max_len - 1);

    typedef logic [num_len-1:0] seg_t;
    typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;

    seg_t                       seg_q [max_len];
    seg_t                       seg_d [max_len];
    logic [max_len_bit_len-1:0] len_q, len_d, lim;
    dir_t                       cur_dir_q, cur_dir_d, pend_dir_q, pend_dir_d;
    logic                       grow_pend_q, grow_pend_d;
    logic                       moved_q, moved_d;
    logic                       self_hit_q, self_hit_d;
    logic                       move, grow_ok, hit;
    logic [HW-1:0]              hx, hy, nx, ny;
    seg_t                       new_head;
    logic [max_len*num_len-1:0] snake_flat;

    always_comb begin
        move     = bus.step & ~bus.freeze & ~self_hit_q;
        hx       = seg_q[0][HW-1:0];
        hy       = seg_q[0][num_len-1:HW];
        nx       = (pend_dir_q == RIGHT) ? ((hx == X_MAX) ? '0 : hx + 1'b1) :
                   (pend_dir_q == LEFT)  ? ((hx == '0) ? X_MAX : hx - 1'b1) : hx;
        ny       = (pend_dir_q == DOWN)  ? ((hy == Y_MAX) ? '0 : hy + 1'b1) :
                   (pend_dir_q == UP)    ? ((hy == '0) ? Y_MAX : hy - 1'b1) : hy;
        new_head = {ny, nx};
        grow_ok  = (grow_pend_q | bus.grow) & (len_q < LEN_CAP);
        // the old tail only stays occupied when the snake grows this move
        lim      = grow_ok ? len_q : len_q - 1'b1;
        hit      = 1'b0;
        for (int i = 0; i < max_len; i++)
            if (max_len_bit_len'(i) < lim && seg_q[i] == new_head) hit = 1'b1;
        seg_d[0] = move ? new_head : seg_q[0];
        for (int i = 1; i < max_len; i++)
            seg_d[i] = move ? seg_q[i-1] : seg_q[i];
        len_d       = (move && grow_ok) ? len_q + 1'b1 : len_q;
        cur_dir_d   = move ? pend_dir_q : cur_dir_q;
        // reversal is judged against the committed direction, so two quick turns cannot fold back
        pend_dir_d  = (bus.dir_valid && bus.dir_in != (cur_dir_q ^ 2'd2)) ? dir_t'(bus.dir_in) : pend_dir_q;
        grow_pend_d = move ? 1'b0 : (grow_pend_q | bus.grow);
        moved_d     = move;
        self_hit_d  = self_hit_q | (move & hit);
        snake_flat  = '0;
        for (int i = 0; i < max_len; i++)
            snake_flat[i*num_len +: num_len] = seg_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < max_len; i++)
                seg_q[i] <= (i < INIT_LEN) ? {HW'(INIT_Y), HW'(INIT_X - i)} : '0;
            len_q       <= max_len_bit_len'(INIT_LEN);
            cur_dir_q   <= RIGHT;
            pend_dir_q  <= RIGHT;
            grow_pend_q <= 1'b0;
            moved_q     <= 1'b0;
            self_hit_q  <= 1'b0;
        end else begin
            for (int i = 0; i < max_len; i++)
                seg_q[i] <= seg_d[i];
            len_q       <= len_d;
            cur_dir_q   <= cur_dir_d;
            pend_dir_q  <= pend_dir_d;
            grow_pend_q <= grow_pend_d;
            moved_q     <= moved_d;
            self_hit_q  <= self_hit_d;
        end
    end

    assign bus.snake    = snake_flat;
    assign bus.len      = len_q;
    assign bus.moved    = moved_q;
    assign bus.self_hit = self_hit_q;
endmodule

// File: tb/tb_snake_body.sv
// tb_snake_body: directed checks of snake_body movement, growth, wrap and collision.
module tb_snake_body;
    localparam int NL = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    snake_body_if #(.max_len(16), .num_len(NL), .max_len_bit_len(4)) bus ();

    snake_body dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [NL-1:0] seg(input int i);
        return bus.snake[i*NL +: NL];
    endfunction

    function automatic logic [NL-1:0] xy(input int x, input int y);
        return {5'(y), 5'(x)};
    endfunction

    task automatic chk_seg(input string tag, input int i, input int x, input int y);
        check(tag, 32'(seg(i)), 32'(xy(x, y)));
    endtask

    // drive one cycle of inputs starting at a falling edge; outputs are sampled at the next falling edge
    task automatic cyc(input logic s, input logic g, input logic dv, input logic [1:0] d, input logic f);
        bus.step = s; bus.grow = g; bus.dir_valid = dv; bus.dir_in = d; bus.freeze = f;
        @(negedge clk);
        bus.step = 1'b0; bus.grow = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 2'd0; bus.freeze = 1'b0;
    endtask

    task automatic steps(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.step = 1'b0; bus.grow = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 2'd0; bus.freeze = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_seg("rst_seg0", 0, 5, 5);
        chk_seg("rst_seg1", 1, 4, 5);
        chk_seg("rst_seg2", 2, 3, 5);
        check("rst_seg3", 32'(seg(3)), 0);
        check("rst_len", 32'(bus.len), 3);
        check("rst_moved", 32'(bus.moved), 0);
        check("rst_hit", 32'(bus.self_hit), 0);

        steps(1);
        chk_seg("s1_seg0", 0, 6, 5);
        chk_seg("s1_seg1", 1, 5, 5);
        chk_seg("s1_seg2", 2, 4, 5);
        check("s1_len", 32'(bus.len), 3);
        check("s1_moved", 32'(bus.moved), 1);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("s1_moved_drop", 32'(bus.moved), 0);

        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        check("grow_wait_len", 32'(bus.len), 3);
        steps(1);
        check("grow_len", 32'(bus.len), 4);
        chk_seg("grow_seg0", 0, 7, 5);
        chk_seg("grow_seg3", 3, 4, 5);
        steps(1);
        check("nogrow_len", 32'(bus.len), 4);
        chk_seg("nogrow_seg0", 0, 8, 5);

        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        steps(1);
        chk_seg("reverse_ign", 0, 9, 5);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        steps(1);
        chk_seg("double_turn", 0, 9, 4);

        do_reset();
        steps(26);
        chk_seg("at_x31", 0, 31, 5);
        steps(1);
        chk_seg("wrap_right", 0, 0, 5);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        steps(5);
        chk_seg("at_y0", 0, 0, 0);
        steps(1);
        chk_seg("wrap_up", 0, 0, 23);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        steps(1);
        chk_seg("wrap_left", 0, 31, 23);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        steps(1);
        chk_seg("wrap_down", 0, 31, 0);

        do_reset();
        repeat (12) cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        check("cap_len", 32'(bus.len), 15);
        chk_seg("cap_head", 0, 17, 5);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        check("cap_drop", 32'(bus.len), 15);
        steps(1);
        check("cap_keep", 32'(bus.len), 15);
        check("cap_nohit", 32'(bus.self_hit), 0);

        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        steps(1);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        steps(1);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        steps(1);
        chk_seg("tail_chase", 0, 5, 5);
        check("tail_nohit", 32'(bus.self_hit), 0);

        do_reset();
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        check("hit_len", 32'(bus.len), 5);
        cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        steps(1);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        steps(1);
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        steps(1);
        chk_seg("hit_head", 0, 6, 5);
        check("hit_flag", 32'(bus.self_hit), 1);
        steps(1);
        chk_seg("hit_hold", 0, 6, 5);
        check("hit_moved", 32'(bus.moved), 0);
        check("hit_sticky", 32'(bus.self_hit), 1);

        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
        chk_seg("freeze_head", 0, 5, 5);
        check("freeze_moved", 32'(bus.moved), 0);
        steps(1);
        chk_seg("unfreeze", 0, 6, 5);
        rst = 1'b1;
        bus.step = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.step = 1'b0;
        chk_seg("midrst_head", 0, 5, 5);
        check("midrst_len", 32'(bus.len), 3);
        check("midrst_moved", 32'(bus.moved), 0);
        check("midrst_hit", 32'(bus.self_hit), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
